// File: rtl/accumulator_stage.sv
// accumulator_stage: three-cycle accumulate/subtract stage (IDLE -> EXEC -> WRITE)
// with a sticky signed-overflow flag and a wrapping operation counter.
module adder_subtractor #(
    parameter int N = 64
) (
    input  logic [N-1:0] factor_a,
    input  logic [N-1:0] factor_b,
    input  logic         operation,
    output logic [N-1:0] result,
    output logic         overflow
);
    assign result = operation ? factor_a - factor_b : factor_a + factor_b;
    assign overflow = (operation ? factor_a[N-1] != factor_b[N-1] : factor_a[N-1] == factor_b[N-1])
                      && result[N-1] != factor_a[N-1];
endmodule

module accumulator_stage #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] operand,
    input  logic         operation,
    input  logic         clear,
    output logic [N-1:0] acc_out,
    output logic         out_valid,
    output logic         overflow,
    output logic [7:0]   op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_t;

    state_t       state_q;
    logic [N-1:0] acc_q, op_q, res_q, sum;
    logic         sel_q, ovf_q, sticky_q, valid_q, add_ovf;
    logic [7:0]   cnt_q;

    adder_subtractor #(.N(N)) u_addsub (
        .factor_a  (acc_q),
        .factor_b  (op_q),
        .operation (sel_q),
        .result    (sum),
        .overflow  (add_ovf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            op_q     <= '0;
            sel_q    <= 1'b0;
            res_q    <= '0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // clear wins over a simultaneous in_valid
                    if (clear) begin
                        acc_q    <= '0;
                        sticky_q <= 1'b0;
                        cnt_q    <= '0;
                    end else if (in_valid) begin
                        op_q    <= operand;
                        sel_q   <= operation;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    res_q   <= sum;
                    ovf_q   <= add_ovf;
                    state_q <= WRITE;
                end
                WRITE: begin
                    acc_q    <= res_q;
                    sticky_q <= sticky_q | ovf_q;
                    cnt_q    <= cnt_q + 8'd1;
                    valid_q  <= 1'b1;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = state_q == IDLE;
    assign acc_out   = acc_q;
    assign out_valid = valid_q;
    assign overflow  = sticky_q;
    assign op_count  = cnt_q;
endmodule

// File: tb/tb_accumulator_stage.sv
// tb_accumulator_stage: randomized scoreboard bench for accumulator_stage (N=8)
// against an integer-arithmetic reference model.
module tb_accumulator_stage;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] operand = '0;
    logic         operation = 1'b0;
    logic         clear = 1'b0;
    logic [N-1:0] acc_out;
    logic         out_valid;
    logic         overflow;
    logic [7:0]   op_count;

    accumulator_stage #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .operand   (operand),
        .operation (operation),
        .clear     (clear),
        .acc_out   (acc_out),
        .out_valid (out_valid),
        .overflow  (overflow),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int cycle = 0;
    int last_pulse = -1;
    int pulses = 0;
    bit btb_mode = 0;

    logic [N-1:0] m_acc = '0;
    logic         m_ovf = 1'b0;
    logic [7:0]   m_cnt = '0;
    logic [N+8:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    always @(posedge clk) cycle++;

    // monitor: every out_valid pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            pulses++;
            if (exp_q.size() == 0) chk("spurious_out_valid", 32'd1, 32'd0);
            else begin
                logic [N+8:0] e;
                e = exp_q.pop_front();
                chk("acc_out", 32'(acc_out), 32'(e[N+8:9]));
                chk("overflow", 32'(overflow), 32'(e[8]));
                chk("op_count", 32'(op_count), 32'(e[7:0]));
            end
            if (btb_mode && last_pulse >= 0) chk("pulse_gap", 32'(cycle - last_pulse), 32'd3);
            last_pulse = cycle;
        end
    end

    task automatic accept(input logic [N-1:0] v, input logic o);
        int a, b, s;
        in_valid = 1'b1; operand = v; operation = o;
        @(posedge clk);
        a = int'($signed(m_acc));
        b = int'($signed(v));
        s = o ? a - b : a + b;
        m_ovf = m_ovf | (s > 127) | (s < -128);
        m_acc = s[N-1:0];
        m_cnt = m_cnt + 8'd1;
        exp_q.push_back({m_acc, m_ovf, m_cnt});
        #1 in_valid = 1'b0; operand = N'($urandom); operation = 1'($urandom);
    endtask

    task automatic do_op(input logic [N-1:0] v, input logic o);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 20) begin @(negedge clk); t++; end
        if (!in_ready) chk("ready_timeout", 32'd0, 32'd1);
        else accept(v, o);
    endtask

    task automatic do_clear();
        @(negedge clk);
        while (!in_ready) @(negedge clk);
        clear = 1'b1; in_valid = 1'b1; operand = 8'h33; operation = 1'b0;
        @(posedge clk);
        m_acc = '0; m_ovf = 1'b0; m_cnt = '0;
        #1 clear = 1'b0; in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 50) begin @(negedge clk); t++; end
        if (exp_q.size() != 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_acc", 32'(acc_out), 32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 32'(in_ready), 32'd1);
        chk("post_rst_cnt", 32'(op_count), 32'd0);

        // latency and in_ready profile of a single add
        accept(8'd5, 1'b0);
        @(negedge clk); chk("ready_exec", 32'(in_ready), 32'd0);
        @(negedge clk); chk("ready_write", 32'(in_ready), 32'd0);
        @(negedge clk); chk("ready_back", 32'(in_ready), 32'd1);
        chk("valid_e2", 32'(out_valid), 32'd1);
        @(negedge clk); chk("valid_one_cycle", 32'(out_valid), 32'd0);

        do_op(8'd7, 1'b1);
        drain();
        chk("sub_neg2", 32'(acc_out), 32'hFE);

        do_clear();
        do_op(8'h7F, 1'b0);
        do_op(8'd1, 1'b0);
        do_op(8'd1, 1'b1);
        drain();
        chk("ovf_sticky", 32'(overflow), 32'd1);
        chk("back_7f", 32'(acc_out), 32'h7F);

        // clear together with in_valid: nothing accepted, no pulse
        do_clear();
        @(negedge clk);
        chk("clr_acc", 32'(acc_out), 32'd0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_cnt", 32'(op_count), 32'd0);
        chk("clr_ready", 32'(in_ready), 32'd1);
        repeat (3) @(negedge clk);
        chk("clr_no_valid", 32'(out_valid), 32'd0);

        // 256 back-to-back increments wrap the counter and accumulator
        pulses = 0; last_pulse = -1; btb_mode = 1;
        for (int i = 0; i < 256; i++) do_op(8'd1, 1'b0);
        drain();
        btb_mode = 0;
        chk("btb_pulses", 32'(pulses), 32'd256);
        chk("btb_cnt", 32'(op_count), 32'd0);
        chk("btb_acc", 32'(acc_out), 32'd0);

        for (int i = 0; i < 60; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if ($urandom_range(0, 15) == 0) do_clear();
            else do_op(N'($urandom), 1'($urandom));
        end
        drain();

        // asynchronous reset while in WRITE aborts the operation
        do_op(8'h40, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_acc", 32'(acc_out), 32'd0);
        chk("abort_cnt", 32'(op_count), 32'd0);
        chk("abort_valid", 32'(out_valid), 32'd0);
        exp_q.delete();
        m_acc = '0; m_ovf = 1'b0; m_cnt = '0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready", 32'(in_ready), 32'd1);
        chk("abort_no_valid", 32'(out_valid), 32'd0);
        do_op(8'd9, 1'b1);
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/accumulator_stage.md
ACCUMULATOR_STAGE -- requirements
Module: accumulator_stage

Interface
REQ-001 Parameter: N, default 64, operand/accumulator width in bits.
REQ-002 clk  input  1  single rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous reset, active-low.
REQ-004 in_valid  input  1  operand/operation pair present.
REQ-005 in_ready  output  1  stage can accept a new pair.
REQ-006 operand  input  N  value combined with the accumulator; drives factor_b of the adder_subtractor.
REQ-007 operation  input  1  0 = acc + operand, 1 = acc - operand.
REQ-008 clear  input  1  synchronous request to zero the accumulator, flags and counter.
REQ-009 acc_out  output  N  current accumulator value, signed two's complement; drives factor_a of the adder_subtractor.
REQ-010 out_valid  output  1  one-cycle pulse: acc_out updated by a completed operation.
REQ-011 overflow  output  1  sticky signed-overflow flag.
REQ-012 op_count  output  8  number of completed operations, modulo 256.

Function
REQ-013 The block SHALL instantiate one adder_subtractor (width N), with factor_a = acc, factor_b = op_reg, operation = sel_reg.
REQ-014 The FSM SHALL have exactly three states: IDLE, EXEC, WRITE; the encoding is free.
REQ-015 in_ready SHALL be 1 only in IDLE; it is combinational from state only, never from in_valid.
REQ-016 IDLE, clear=1: next edge sets acc=0, overflow=0, op_count=0; the FSM stays in IDLE; in_valid is ignored that cycle; clear has priority over in_valid.
REQ-017 IDLE, clear=0, in_valid=1: next edge captures op_reg=operand and sel_reg=operation, then moves to EXEC.
REQ-018 EXEC: next edge captures the adder result into res_reg and the overflow condition into ovf_reg, then moves to WRITE.
REQ-019 WRITE: next edge sets acc=res_reg, overflow = overflow OR ovf_reg, op_count = op_count+1, out_valid=1 for exactly the following cycle; the FSM returns to IDLE.
REQ-020 Latency: for a pair accepted at edge E0, acc_out and out_valid SHALL reflect it after edge E0+2; in_ready SHALL be 1 again in that same cycle. Maximum throughput is one operation per 3 cycles.
REQ-021 clear, in_valid, operand and operation SHALL be ignored in EXEC and WRITE; operand and operation need not be held after acceptance.
REQ-022 Arithmetic SHALL wrap modulo 2^N with no saturation.
REQ-023 Overflow condition, evaluated with a=acc, b=op_reg, r=result:
- add: a[N-1]==b[N-1] and r[N-1]!=a[N-1];
- sub: a[N-1]!=b[N-1] and r[N-1]!=a[N-1].
REQ-024 overflow SHALL stay 1 until reset or clear.
REQ-025 op_count SHALL wrap from 255 to 0 without a flag.
REQ-026 out_valid SHALL be 0 in every cycle other than the one defined in REQ-019.

Reset
REQ-027 While rst_n=0, regardless of clk: state=IDLE, acc=0, op_reg=0, sel_reg=0, res_reg=0, ovf_reg=0, overflow=0, op_count=0, out_valid=0.
REQ-028 Reset asserted in EXEC or WRITE SHALL abort the operation; acc is not updated and out_valid does not pulse.
REQ-029 After rst_n deasserts, in_ready SHALL be 1 on the first clock; no spurious out_valid.

Verification (N=8)
REQ-030 Reset, then apply (operand=5, op=0, in_valid=1) at E0 -> in_ready=0 for 2 cycles; after E0+2: acc_out=5, out_valid=1 for one cycle, op_count=1.
REQ-031 From acc=5, apply (operand=7, op=1) -> acc_out=0xFE (-2), overflow=0.
REQ-032 From acc=0x7F, apply (operand=1, op=0) -> acc_out=0x80, overflow=1; then (1, op=1) -> acc_out=0x7F, overflow still 1.
REQ-033 Assert clear together with in_valid in IDLE -> acc_out=0, overflow=0, op_count=0, no operation accepted, no out_valid.
REQ-034 Run 256 back-to-back add-1 operations from acc=0 -> op_count=0, acc_out=0x00, 256 out_valid pulses exactly 3 cycles apart.
REQ-035 Drop rst_n mid-cycle while in WRITE -> outputs zero immediately, with no clock edge needed; no out_valid; in_ready=1 after release.
